// File: rtl/bus_rr_arbiter_pkg.sv
// Shared definitions for the memory-bus round-robin arbiter: well-known
// requester slots, default requester count and the arbiter state encoding.
package bus_rr_arbiter_pkg;

  // Fixed requester slots on the shared memory bus; the remaining slots are spare.
  localparam int BUS_DCACHE = 0;
  localparam int BUS_ICACHE = 1;
  localparam int BUS_NREQ   = 8;

  // IDLE: nobody owns the bus. GRANT: one owner drives the bus.
  // TURN: one dead cycle so the OR-combined bus never mixes two masters.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } bus_state_t;

endpackage

// File: rtl/bus_rr_arbiter_if.sv
// Handshake bundle between the bus masters and the arbiter. The arbiter
// connects through the slave modport, the requesters through the master modport.
interface bus_rr_arbiter_if #(
  parameter int NREQ = 8,
  parameter int OW   = 3
);

  logic [NREQ-1:0] bus_req;
  logic            bus_ready;
  logic [NREQ-1:0] bus_ack;
  logic [OW-1:0]   bus_owner;
  logic            bus_busy;
  logic            err_clr;
  logic            err_timeout;
  logic [OW-1:0]   err_owner;

  modport slave (
    input  bus_req, bus_ready, err_clr,
    output bus_ack, bus_owner, bus_busy, err_timeout, err_owner
  );

  modport master (
    output bus_req, bus_ready, err_clr,
    input  bus_ack, bus_owner, bus_busy, err_timeout, err_owner
  );

endinterface

// File: rtl/bus_rr_arbiter_pick.sv
// Combinational round-robin pick: finds the first set bit of elig scanning
// from last_owner+1 upward, wrapping modulo NREQ. Kept standalone so another
// arbiter (e.g. a writeback port) can reuse it.
module rr_pick #(
  parameter int NREQ = 8,
  parameter int OW   = 3
) (
  input  logic [NREQ-1:0] elig,
  input  logic [OW-1:0]   last_owner,
  output logic            any,
  output logic [OW-1:0]   pick
);

  // Scan NREQ positions starting just after the previous owner, so the
  // previous owner itself is visited last (lowest priority).
  always_comb begin
    logic         found;
    logic [OW-1:0] idx;
    any   = |elig;
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = OW'((int'(last_owner) + k) % NREQ);
      if (!found && elig[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Sequential round-robin arbiter for the shared memory bus. Grants are held
// until the owner drops its request, every hand-over passes through a one-cycle
// turnaround, and a watchdog revokes owners that stall without bus_ready.
module bus_rr_arbiter
  import bus_rr_arbiter_pkg::*;
#(
  parameter int NREQ        = BUS_NREQ,
  parameter int OW          = 3,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst,
  bus_rr_arbiter_if.slave    bus
);

  // Counter only has to reach WDOG_CYCLES-1.
  localparam int            WW        = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [WW-1:0] WDOG_LAST = WW'((WDOG_CYCLES > 0) ? WDOG_CYCLES - 1 : 0);
  localparam bit            WDOG_EN   = (WDOG_CYCLES != 0);

  bus_state_t      state_reg;
  logic [NREQ-1:0] ack_reg;
  logic [OW-1:0]   owner_reg;
  logic            busy_reg;
  logic [OW-1:0]   last_owner_reg;
  logic [NREQ-1:0] mask_reg;
  logic [WW-1:0]   wdog_reg;
  logic            err_timeout_reg;
  logic [OW-1:0]   err_owner_reg;

  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] mask_next;
  logic            pick_any;
  logic [OW-1:0]   pick;
  logic            owner_req;
  logic            wdog_fire;

  assign elig      = bus.bus_req & ~mask_reg;
  assign owner_req = bus.bus_req[owner_reg];

  // Watchdog fires on the last allowed granted cycle if the beat still has not completed.
  assign wdog_fire = WDOG_EN && (state_reg == GRANT) && owner_req &&
                     (wdog_reg == WDOG_LAST) && !bus.bus_ready;

  // A master's mask bit survives only while it keeps requesting; revocation sets it.
  always_comb begin
    mask_next = mask_reg & bus.bus_req;
    if (wdog_fire) begin
      mask_next = mask_next | (NREQ'(1) << owner_reg);
    end
  end

  rr_pick #(
    .NREQ (NREQ),
    .OW   (OW)
  ) u_pick (
    .elig       (elig),
    .last_owner (last_owner_reg),
    .any        (pick_any),
    .pick       (pick)
  );

  // Arbiter FSM with registered grant, owner, watchdog and error state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      ack_reg         <= '0;
      owner_reg       <= '0;
      busy_reg        <= 1'b0;
      last_owner_reg  <= OW'(NREQ - 1);
      mask_reg        <= '0;
      wdog_reg        <= '0;
      err_timeout_reg <= 1'b0;
      err_owner_reg   <= '0;
    end else begin
      mask_reg <= mask_next;

      // A watchdog event wins over a simultaneous clear.
      if (wdog_fire) begin
        err_timeout_reg <= 1'b1;
        err_owner_reg   <= owner_reg;
      end else if (bus.err_clr) begin
        err_timeout_reg <= 1'b0;
      end

      case (state_reg)
        IDLE, TURN: begin
          wdog_reg <= '0;
          if (pick_any) begin
            ack_reg        <= NREQ'(1) << pick;
            owner_reg      <= pick;
            last_owner_reg <= pick;
            busy_reg       <= 1'b1;
            state_reg      <= GRANT;
          end else begin
            ack_reg   <= '0;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        end
        GRANT: begin
          if (!owner_req || wdog_fire) begin
            ack_reg   <= '0;
            busy_reg  <= 1'b0;
            wdog_reg  <= '0;
            state_reg <= TURN;
          end else if (bus.bus_ready) begin
            wdog_reg <= '0;
          end else begin
            wdog_reg <= wdog_reg + 1'b1;
          end
        end
        default: begin
          ack_reg   <= '0;
          busy_reg  <= 1'b0;
          wdog_reg  <= '0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.bus_ack     = ack_reg;
  assign bus.bus_owner   = owner_reg;
  assign bus.bus_busy    = busy_reg;
  assign bus.err_timeout = err_timeout_reg;
  assign bus.err_owner   = err_owner_reg;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed bench for bus_rr_arbiter with an 8-requester bus and a 16-cycle watchdog.
module tb_bus_rr_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  bus_rr_arbiter_if #(.NREQ(8), .OW(3)) bus ();

  bus_rr_arbiter #(
    .NREQ        (8),
    .OW          (3),
    .WDOG_CYCLES (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Grant must be at most one-hot on every cycle.
  always @(negedge clk) begin
    checks++;
    assert ($onehot0(bus.bus_ack)) else begin
      errors++;
      $error("FAIL onehot observed=%b expected=at_most_one_bit", bus.bus_ack);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench did not finish");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.bus_req   = '0;
    bus.bus_ready = 1'b0;
    bus.err_clr   = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [2:0] order [7];
    logic [2:0] o;
    order = '{3'd0, 3'd1, 3'd5, 3'd0, 3'd1, 3'd5, 3'd0};

    bus.bus_req   = '0;
    bus.bus_ready = 1'b0;
    bus.err_clr   = 1'b0;
    step();
    chk("rst_ack",   32'(bus.bus_ack), 32'h0);
    chk("rst_busy",  32'(bus.bus_busy), 32'h0);
    chk("rst_owner", 32'(bus.bus_owner), 32'h0);
    chk("rst_err",   32'(bus.err_timeout), 32'h0);
    chk("rst_eown",  32'(bus.err_owner), 32'h0);

    // 1: two requesters, master 0 first, then handover via turnaround
    rst = 1'b0;
    bus.bus_req = 8'b0000_0011;
    step();
    chk("t1_ack0", 32'(bus.bus_ack), 32'h01);
    chk("t1_busy", 32'(bus.bus_busy), 32'h1);
    bus.bus_req = 8'b0000_0010;
    step();
    chk("t1_turn", 32'(bus.bus_ack), 32'h00);
    step();
    chk("t1_ack1",  32'(bus.bus_ack), 32'h02);
    chk("t1_owner", 32'(bus.bus_owner), 32'h1);
    bus.bus_req = '0;
    step();
    step();

    // 2: three continuous requesters rotate 0,1,5 with one-cycle gaps
    do_reset();
    bus.bus_req = 8'b0010_0011;
    step();
    for (int g = 0; g < 6; g++) begin
      o = order[g];
      chk($sformatf("t2_ack_g%0d", g), 32'(bus.bus_ack), 32'(8'h01 << o));
      chk($sformatf("t2_own_g%0d", g), 32'(bus.bus_owner), 32'(o));
      bus.bus_ready = 1'b1;
      for (int b = 0; b < 4; b++) step();
      bus.bus_ready = 1'b0;
      bus.bus_req[o] = 1'b0;
      step();
      chk($sformatf("t2_gap_g%0d", g), 32'(bus.bus_ack), 32'h0);
      bus.bus_req[o] = 1'b1;
      step();
    end
    chk("t2_ack_wrap", 32'(bus.bus_ack), 32'h01);
    bus.bus_req = '0;
    step();
    step();

    // 3: lone requester re-raising in TURN gets the bus back after two cycles
    do_reset();
    bus.bus_req = 8'b0000_1000;
    step();
    chk("t3_ack", 32'(bus.bus_ack), 32'h08);
    bus.bus_req = '0;
    step();
    chk("t3_turn", 32'(bus.bus_ack), 32'h00);
    bus.bus_req = 8'b0000_1000;
    step();
    chk("t3_regrant", 32'(bus.bus_ack), 32'h08);
    bus.bus_req = '0;
    step();
    step();

    // 4: watchdog revokes master 1 after 16 stalled cycles
    do_reset();
    bus.bus_req = 8'b0000_0010;
    step();
    chk("t4_ack1", 32'(bus.bus_ack), 32'h02);
    bus.bus_req = 8'b0000_0011;
    for (int c = 0; c < 15; c++) step();
    chk("t4_hold", 32'(bus.bus_ack), 32'h02);
    step();
    chk("t4_revoke", 32'(bus.bus_ack), 32'h00);
    chk("t4_busy",   32'(bus.bus_busy), 32'h0);
    chk("t4_err",    32'(bus.err_timeout), 32'h1);
    chk("t4_eown",   32'(bus.err_owner), 32'h1);
    step();
    chk("t4_ack0", 32'(bus.bus_ack), 32'h01);
    bus.bus_req = 8'b0000_0010;
    step();
    step();
    chk("t4_masked_a", 32'(bus.bus_ack), 32'h00);
    step();
    chk("t4_masked_b", 32'(bus.bus_ack), 32'h00);
    bus.bus_req = '0;
    step();
    bus.bus_req = 8'b0000_0010;
    step();
    chk("t4_unmasked", 32'(bus.bus_ack), 32'h02);

    // 5: err_clr colliding with a new watchdog event, then err_clr alone
    bus.bus_req = '0;
    step();
    step();
    bus.bus_req = 8'b0000_0001;
    step();
    chk("t5_ack0", 32'(bus.bus_ack), 32'h01);
    for (int c = 0; c < 15; c++) step();
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
    chk("t5_revoke",   32'(bus.bus_ack), 32'h00);
    chk("t5_err_set",  32'(bus.err_timeout), 32'h1);
    chk("t5_eown",     32'(bus.err_owner), 32'h0);
    bus.bus_req = '0;
    step();
    chk("t5_sticky", 32'(bus.err_timeout), 32'h1);
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
    chk("t5_cleared", 32'(bus.err_timeout), 32'h0);
    step();

    // 6: asynchronous reset mid-grant
    do_reset();
    bus.bus_req = 8'b0000_0001;
    step();
    chk("t6_ack0", 32'(bus.bus_ack), 32'h01);
    #3;
    rst = 1'b1;
    #1;
    chk("t6_async_ack",  32'(bus.bus_ack), 32'h00);
    chk("t6_async_busy", 32'(bus.bus_busy), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.bus_req = 8'b0000_0100;
    step();
    chk("t6_ack2",   32'(bus.bus_ack), 32'h04);
    chk("t6_owner2", 32'(bus.bus_owner), 32'h2);
    bus.bus_req = '0;
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
